// File: rtl/pcie_router_pkg.sv
// Shared types and helpers for the PCIe CQ/CC router.
// No logic of its own; zero latency.
// Backpressure: not applicable.
package pcie_router_pkg;

    localparam int CQ_BAR_ID_LSB = 112;
    localparam int BAR_ID_W      = 3;
    localparam int MAX_PORTS     = 8;

    typedef enum logic {IDLE, LOCK} cc_state_t;

    // First requester strictly after ptr, wrapping over n ports.
    function automatic logic [2:0] rr_pick(input logic [MAX_PORTS-1:0] req,
                                           input logic [2:0] ptr, input int n);
        logic [2:0] pick;
        logic       found;
        int         idx;
        pick  = '0;
        found = 1'b0;
        for (int k = 1; k <= MAX_PORTS; k++) begin
            idx = (int'(ptr) + k) % n;
            if (k <= n && !found && req[idx]) begin
                pick  = 3'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/pcie_axis_skid.sv
// Two-entry AXI-stream skid buffer.
// Latency: 1 cycle from input handshake to output valid.
// Backpressure: wr_rdy is a register (not full), so the upstream sees no combinational path.
module pcie_axis_skid #(
    parameter int DATA_W = 256,
    parameter int USER_W = 85,
    parameter int KEEP_W = 8
) (
    input  logic              core_clk,
    input  logic              arst_n,
    input  logic [DATA_W-1:0] wr_dat,
    input  logic [USER_W-1:0] wr_user,
    input  logic [KEEP_W-1:0] wr_keep,
    input  logic              wr_last,
    input  logic              wr_vld,
    output logic              wr_rdy,
    output logic [DATA_W-1:0] rd_dat,
    output logic [USER_W-1:0] rd_user,
    output logic [KEEP_W-1:0] rd_keep,
    output logic              rd_last,
    output logic              rd_vld,
    input  logic              rd_rdy
);

    localparam int W = DATA_W + USER_W + KEEP_W + 1;

    logic [W-1:0] mem [2];
    logic         wr_ptr, rd_ptr;
    logic [1:0]   cnt, cnt_d;
    logic         rdy_q;
    logic         wr_fire, rd_fire;

    assign wr_fire = wr_vld & rdy_q;
    assign rd_fire = rd_vld & rd_rdy;
    assign wr_rdy  = rdy_q;
    assign rd_vld  = (cnt != 2'd0);
    assign {rd_dat, rd_user, rd_keep, rd_last} = mem[rd_ptr];

    always_comb begin
        cnt_d = cnt + {1'b0, wr_fire} - {1'b0, rd_fire};
    end

    always_ff @(posedge core_clk or negedge arst_n) begin
        if (!arst_n) begin
            cnt    <= '0;
            rdy_q  <= 1'b0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            cnt   <= cnt_d;
            rdy_q <= (cnt_d != 2'd2);
            if (wr_fire) wr_ptr <= ~wr_ptr;
            if (rd_fire) rd_ptr <= ~rd_ptr;
        end
    end

    always_ff @(posedge core_clk) begin
        if (wr_fire) mem[wr_ptr] <= {wr_dat, wr_user, wr_keep, wr_last};
    end

endmodule

// File: rtl/pcie_cq_cc_router.sv
// Routes CQ packets to one completer by BAR ID; merges completer CC streams with packet-locked round robin.
// Latency: CQ 1 cycle (skid), CC combinational after a 1-cycle grant bubble. PCIE_ROUTER_STATS_EN adds counters.
// Backpressure: CQ head waits only on the chosen port's tready (dropped packets drain freely); CC stalls via s_axis_cc_tready.
module pcie_cq_cc_router
    import pcie_router_pkg::*;
#(
    parameter int                   N_PORTS   = 2,
    parameter int                   DATA_W    = 256,
    parameter int                   KEEP_W    = 8,
    parameter int                   CQ_USER_W = 85,
    parameter int                   CC_USER_W = 33,
    parameter logic [N_PORTS*7-1:0] BAR_MASK  = 14'h0201
) (
    input  logic                           user_clk,
    input  logic                           reset_n,
`ifdef PCIE_ROUTER_STATS_EN
    input  logic                           stat_clr,
    output logic [N_PORTS*32-1:0]          stat_pkt_cnt,
    output logic [31:0]                    stat_drop_cnt,
`endif
    input  logic [DATA_W-1:0]              m_axis_cq_tdata,
    input  logic [CQ_USER_W-1:0]           m_axis_cq_tuser,
    input  logic [KEEP_W-1:0]              m_axis_cq_tkeep,
    input  logic                           m_axis_cq_tlast,
    input  logic                           m_axis_cq_tvalid,
    output logic                           m_axis_cq_tready,
    output logic [N_PORTS*DATA_W-1:0]      cq_out_tdata,
    output logic [N_PORTS*CQ_USER_W-1:0]   cq_out_tuser,
    output logic [N_PORTS*KEEP_W-1:0]      cq_out_tkeep,
    output logic [N_PORTS-1:0]             cq_out_tlast,
    output logic [N_PORTS-1:0]             cq_out_tvalid,
    input  logic [N_PORTS-1:0]             cq_out_tready,
    input  logic [N_PORTS*DATA_W-1:0]      cc_in_tdata,
    input  logic [N_PORTS*CC_USER_W-1:0]   cc_in_tuser,
    input  logic [N_PORTS*KEEP_W-1:0]      cc_in_tkeep,
    input  logic [N_PORTS-1:0]             cc_in_tlast,
    input  logic [N_PORTS-1:0]             cc_in_tvalid,
    output logic [N_PORTS-1:0]             cc_in_tready,
    output logic [DATA_W-1:0]              s_axis_cc_tdata,
    output logic [CC_USER_W-1:0]           s_axis_cc_tuser,
    output logic [KEEP_W-1:0]              s_axis_cc_tkeep,
    output logic                           s_axis_cc_tlast,
    output logic                           s_axis_cc_tvalid,
    input  logic                           s_axis_cc_tready
);

    localparam int PW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

    logic [DATA_W-1:0]    hd_dat;
    logic [CQ_USER_W-1:0] hd_user;
    logic [KEEP_W-1:0]    hd_keep;
    logic                 hd_last, hd_vld, hd_rdy, hd_fire;

    pcie_axis_skid #(.DATA_W(DATA_W), .USER_W(CQ_USER_W), .KEEP_W(KEEP_W)) u_cq_skid (
        .core_clk (user_clk),
        .arst_n   (reset_n),
        .wr_dat   (m_axis_cq_tdata),
        .wr_user  (m_axis_cq_tuser),
        .wr_keep  (m_axis_cq_tkeep),
        .wr_last  (m_axis_cq_tlast),
        .wr_vld   (m_axis_cq_tvalid),
        .wr_rdy   (m_axis_cq_tready),
        .rd_dat   (hd_dat),
        .rd_user  (hd_user),
        .rd_keep  (hd_keep),
        .rd_last  (hd_last),
        .rd_vld   (hd_vld),
        .rd_rdy   (hd_rdy)
    );

    logic                sop_q, drop_q, drop_c, cur_drop;
    logic [PW-1:0]       dest_q, dest_c, cur_dest;
    logic [BAR_ID_W-1:0] bar;

    assign bar = hd_dat[CQ_BAR_ID_LSB +: BAR_ID_W];

    // Descending scan so the lowest matching port wins; BAR 7 never matches.
    always_comb begin
        dest_c = '0;
        drop_c = 1'b1;
        if (bar != {BAR_ID_W{1'b1}}) begin
            for (int p = N_PORTS - 1; p >= 0; p--) begin
                if (BAR_MASK[p*7 + int'(bar)]) begin
                    dest_c = PW'(p);
                    drop_c = 1'b0;
                end
            end
        end
    end

    assign cur_dest = sop_q ? dest_c : dest_q;
    assign cur_drop = sop_q ? drop_c : drop_q;
    assign hd_rdy   = cur_drop | cq_out_tready[cur_dest];
    assign hd_fire  = hd_vld & hd_rdy;

    always_ff @(posedge user_clk or negedge reset_n) begin
        if (!reset_n) begin
            sop_q  <= 1'b1;
            dest_q <= '0;
            drop_q <= 1'b0;
        end else if (hd_fire) begin
            sop_q <= hd_last;
            if (sop_q) begin
                dest_q <= dest_c;
                drop_q <= drop_c;
            end
        end
    end

    for (genvar p = 0; p < N_PORTS; p++) begin : g_cq_out
        assign cq_out_tdata[p*DATA_W +: DATA_W]       = hd_dat;
        assign cq_out_tuser[p*CQ_USER_W +: CQ_USER_W] = hd_user;
        assign cq_out_tkeep[p*KEEP_W +: KEEP_W]       = hd_keep;
        assign cq_out_tlast[p]                        = hd_last;
        assign cq_out_tvalid[p] = hd_vld & ~cur_drop & (cur_dest == PW'(p));
    end

    cc_state_t     state_q, state_d;
    logic [PW-1:0] grant_q, grant_d, rr_q, rr_d;

    always_comb begin
        state_d          = state_q;
        grant_d          = grant_q;
        rr_d             = rr_q;
        s_axis_cc_tdata  = '0;
        s_axis_cc_tuser  = '0;
        s_axis_cc_tlast  = 1'b0;
        s_axis_cc_tvalid = 1'b0;
        s_axis_cc_tkeep  = cc_in_tkeep[grant_q*KEEP_W +: KEEP_W];
        cc_in_tready     = '0;
        case (state_q)
            IDLE: begin
                if (|cc_in_tvalid) begin
                    grant_d = PW'(rr_pick(MAX_PORTS'(cc_in_tvalid), 3'(rr_q), N_PORTS));
                    state_d = LOCK;
                end
            end
            LOCK: begin
                s_axis_cc_tdata       = cc_in_tdata[grant_q*DATA_W +: DATA_W];
                s_axis_cc_tuser       = cc_in_tuser[grant_q*CC_USER_W +: CC_USER_W];
                s_axis_cc_tlast       = cc_in_tlast[grant_q];
                s_axis_cc_tvalid      = cc_in_tvalid[grant_q];
                cc_in_tready[grant_q] = s_axis_cc_tready;
                if (s_axis_cc_tvalid && s_axis_cc_tready && s_axis_cc_tlast) begin
                    rr_d    = grant_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge user_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            rr_q    <= PW'(N_PORTS - 1);
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            rr_q    <= rr_d;
        end
    end

`ifdef PCIE_ROUTER_STATS_EN
    logic [31:0] pkt_cnt [N_PORTS];
    logic [31:0] drop_cnt;

    always_ff @(posedge user_clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int p = 0; p < N_PORTS; p++) pkt_cnt[p] <= '0;
            drop_cnt <= '0;
        end else if (stat_clr) begin
            for (int p = 0; p < N_PORTS; p++) pkt_cnt[p] <= '0;
            drop_cnt <= '0;
        end else if (hd_fire && sop_q) begin
            if (drop_c) drop_cnt <= drop_cnt + 32'd1;
            else        pkt_cnt[dest_c] <= pkt_cnt[dest_c] + 32'd1;
        end
    end

    for (genvar p = 0; p < N_PORTS; p++) begin : g_stat
        assign stat_pkt_cnt[p*32 +: 32] = pkt_cnt[p];
    end
    assign stat_drop_cnt = drop_cnt;
`endif

endmodule

// File: tb/tb_pcie_cq_cc_router.sv
// Directed bench for pcie_cq_cc_router (N_PORTS=2, BAR_MASK=14'h0201: BAR0->port0, BAR2->port1).
// Beats carry {tag,beat} in tdata[15:0]; monitors log handshakes on the falling edge.
module tb_pcie_cq_cc_router;

    localparam int N   = 2;
    localparam int DW  = 256;
    localparam int KW  = 8;
    localparam int QUW = 85;
    localparam int CUW = 33;

    logic user_clk = 1'b0;
    logic reset_n  = 1'b0;
    always #5 user_clk = ~user_clk;

    logic [DW-1:0]    m_axis_cq_tdata  = '0;
    logic [QUW-1:0]   m_axis_cq_tuser  = '0;
    logic [KW-1:0]    m_axis_cq_tkeep  = '0;
    logic             m_axis_cq_tlast  = 1'b0;
    logic             m_axis_cq_tvalid = 1'b0;
    logic             m_axis_cq_tready;
    logic [N*DW-1:0]  cq_out_tdata;
    logic [N*QUW-1:0] cq_out_tuser;
    logic [N*KW-1:0]  cq_out_tkeep;
    logic [N-1:0]     cq_out_tlast, cq_out_tvalid;
    logic [N-1:0]     cq_out_tready = '0;
    logic [N*DW-1:0]  cc_in_tdata   = '0;
    logic [N*CUW-1:0] cc_in_tuser   = '0;
    logic [N*KW-1:0]  cc_in_tkeep   = '0;
    logic [N-1:0]     cc_in_tlast   = '0;
    logic [N-1:0]     cc_in_tvalid  = '0;
    logic [N-1:0]     cc_in_tready;
    logic [DW-1:0]    s_axis_cc_tdata;
    logic [CUW-1:0]   s_axis_cc_tuser;
    logic [KW-1:0]    s_axis_cc_tkeep;
    logic             s_axis_cc_tlast, s_axis_cc_tvalid;
    logic             s_axis_cc_tready = 1'b1;
`ifdef PCIE_ROUTER_STATS_EN
    logic             stat_clr = 1'b0;
    logic [N*32-1:0]  stat_pkt_cnt;
    logic [31:0]      stat_drop_cnt;
`endif

    pcie_cq_cc_router dut (
        .user_clk         (user_clk),
        .reset_n          (reset_n),
`ifdef PCIE_ROUTER_STATS_EN
        .stat_clr         (stat_clr),
        .stat_pkt_cnt     (stat_pkt_cnt),
        .stat_drop_cnt    (stat_drop_cnt),
`endif
        .m_axis_cq_tdata  (m_axis_cq_tdata),
        .m_axis_cq_tuser  (m_axis_cq_tuser),
        .m_axis_cq_tkeep  (m_axis_cq_tkeep),
        .m_axis_cq_tlast  (m_axis_cq_tlast),
        .m_axis_cq_tvalid (m_axis_cq_tvalid),
        .m_axis_cq_tready (m_axis_cq_tready),
        .cq_out_tdata     (cq_out_tdata),
        .cq_out_tuser     (cq_out_tuser),
        .cq_out_tkeep     (cq_out_tkeep),
        .cq_out_tlast     (cq_out_tlast),
        .cq_out_tvalid    (cq_out_tvalid),
        .cq_out_tready    (cq_out_tready),
        .cc_in_tdata      (cc_in_tdata),
        .cc_in_tuser      (cc_in_tuser),
        .cc_in_tkeep      (cc_in_tkeep),
        .cc_in_tlast      (cc_in_tlast),
        .cc_in_tvalid     (cc_in_tvalid),
        .cc_in_tready     (cc_in_tready),
        .s_axis_cc_tdata  (s_axis_cc_tdata),
        .s_axis_cc_tuser  (s_axis_cc_tuser),
        .s_axis_cc_tkeep  (s_axis_cc_tkeep),
        .s_axis_cc_tlast  (s_axis_cc_tlast),
        .s_axis_cc_tvalid (s_axis_cc_tvalid),
        .s_axis_cc_tready (s_axis_cc_tready)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    int oh_viol  = 0;
    int side_err = 0;
    bit rdy_toggle = 1'b0;

    logic [19:0] cq_log [$];
    logic [16:0] cc_log [$];
    int          cc_cyc [$];
    int          cc_pk [N][$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [19:0] cqe(input int p, input int tag, input int beat, input bit last);
        return {3'(p), 8'(tag), 8'(beat), last};
    endfunction

    function automatic logic [16:0] cce(input int tag, input int beat, input bit last);
        return {8'(tag), 8'(beat), last};
    endfunction

    always @(posedge user_clk) cyc <= cyc + 1;

    always @(negedge user_clk) begin
        for (int p = 0; p < N; p++) begin
            if (cq_out_tvalid[p] && cq_out_tready[p]) begin
                cq_log.push_back({3'(p), cq_out_tdata[p*DW +: 16], cq_out_tlast[p]});
                if (cq_out_tuser[p*QUW +: 8] != cq_out_tdata[p*DW+8 +: 8] || cq_out_tkeep[p*KW +: KW] != '1)
                    side_err++;
            end
        end
        if (s_axis_cc_tvalid && s_axis_cc_tready) begin
            cc_log.push_back({s_axis_cc_tdata[15:0], s_axis_cc_tlast});
            cc_cyc.push_back(cyc);
            if (s_axis_cc_tuser[7:0] != s_axis_cc_tdata[15:8] || s_axis_cc_tkeep != '1) side_err++;
        end
        if ($countones(cq_out_tvalid) > 1 || $countones(cc_in_tready) > 1) oh_viol++;
    end

    // Completer model: each port streams queued packets, entry = (len << 8) | tag.
    initial begin : cc_drv
        int len [N];
        int beat [N];
        int tg [N];
        bit act [N];
        bit acc [N];
        int e;
        for (int p = 0; p < N; p++) begin
            len[p] = 1; beat[p] = 0; tg[p] = 0; act[p] = 1'b0; acc[p] = 1'b0;
        end
        forever begin
            @(negedge user_clk);
            for (int p = 0; p < N; p++) acc[p] = cc_in_tvalid[p] && cc_in_tready[p];
            @(posedge user_clk);
            #1;
            for (int p = 0; p < N; p++) begin
                if (acc[p]) begin
                    if (beat[p] == len[p] - 1) act[p] = 1'b0;
                    else beat[p]++;
                end
                if (!act[p] && cc_pk[p].size() > 0) begin
                    e       = cc_pk[p].pop_front();
                    tg[p]   = e & 255;
                    len[p]  = e >> 8;
                    beat[p] = 0;
                    act[p]  = 1'b1;
                end
                cc_in_tvalid[p]             = act[p];
                cc_in_tdata[p*DW +: 16]     = {8'(tg[p]), 8'(beat[p])};
                cc_in_tuser[p*CUW +: 8]     = 8'(tg[p]);
                cc_in_tkeep[p*KW +: KW]     = '1;
                cc_in_tlast[p]              = act[p] && (beat[p] == len[p] - 1);
            end
            s_axis_cc_tready = rdy_toggle ? ~s_axis_cc_tready : 1'b1;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge user_clk);
        #1;
    endtask

    task automatic send_beat(input int bar, input int tag, input int beat, input bit last, output logic ok);
        logic acc;
        m_axis_cq_tdata            = '0;
        m_axis_cq_tdata[114:112]   = 3'(bar);
        m_axis_cq_tdata[15:0]      = {8'(tag), 8'(beat)};
        m_axis_cq_tuser            = QUW'(tag);
        m_axis_cq_tkeep            = '1;
        m_axis_cq_tlast            = last;
        m_axis_cq_tvalid           = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge user_clk);
            acc = m_axis_cq_tready;
            @(posedge user_clk);
            #1;
            ok = acc;
        end
    endtask

    task automatic send_cq(input int bar, input int nb, input int tag);
        logic ok;
        logic all_ok;
        all_ok = 1'b1;
        for (int b = 0; b < nb; b++) begin
            send_beat(bar, tag, b, b == nb - 1, ok);
            if (!ok) all_ok = 1'b0;
        end
        m_axis_cq_tvalid = 1'b0;
        chk($sformatf("cq_accept_%0h", tag), all_ok, 1'b1);
    endtask

    initial begin : main
        logic ok;

        step(3);
        chk("rst_cq_tready", m_axis_cq_tready, 1'b0);
        chk("rst_cq_out_tvalid", cq_out_tvalid, 2'b00);
        chk("rst_cc_tvalid", s_axis_cc_tvalid, 1'b0);
        chk("rst_cc_in_tready", cc_in_tready, 2'b00);
`ifdef PCIE_ROUTER_STATS_EN
        chk("rst_stat_drop", stat_drop_cnt, 0);
        chk("rst_stat_pkt", stat_pkt_cnt, 0);
`endif
        reset_n = 1'b1;
        step(2);
        chk("cq_tready_after_rst", m_axis_cq_tready, 1'b1);

        // BAR0 1-beat read to port0, BAR2 3-beat write to port1
        cq_out_tready = 2'b11;
        cq_log.delete();
        send_cq(0, 1, 8'h10);
        send_cq(2, 3, 8'h11);
        step(6);
        chk("t1_count", cq_log.size(), 4);
        if (cq_log.size() == 4) begin
            chk("t1_b0", cq_log[0], cqe(0, 8'h10, 0, 1'b1));
            chk("t1_b1", cq_log[1], cqe(1, 8'h11, 0, 1'b0));
            chk("t1_b2", cq_log[2], cqe(1, 8'h11, 1, 1'b0));
            chk("t1_b3", cq_log[3], cqe(1, 8'h11, 2, 1'b1));
        end

        // Head for port1 must ignore port0's ready
        cq_log.delete();
        cq_out_tready = 2'b01;
        send_cq(2, 1, 8'h12);
        step(5);
        chk("hold_count", cq_log.size(), 0);
        chk("hold_tvalid", cq_out_tvalid, 2'b10);
        cq_out_tready = 2'b10;
        step(2);
        chk("hold_release_count", cq_log.size(), 1);
        if (cq_log.size() == 1) chk("hold_release_beat", cq_log[0], cqe(1, 8'h12, 0, 1'b1));

        // Drops: BAR3 (unmapped), BAR1 (unmapped in port1), BAR7; no ready needed
        cq_out_tready = 2'b00;
        cq_log.delete();
        send_cq(3, 4, 8'h20);
        send_cq(1, 1, 8'h21);
        send_cq(7, 2, 8'h22);
        step(4);
        chk("drop_no_out", cq_log.size(), 0);
        chk("drop_tvalid", cq_out_tvalid, 2'b00);
`ifdef PCIE_ROUTER_STATS_EN
        chk("stat_drop", stat_drop_cnt, 3);
        chk("stat_pkt0", stat_pkt_cnt[31:0], 1);
        chk("stat_pkt1", stat_pkt_cnt[63:32], 2);
        stat_clr = 1'b1;
        step(1);
        stat_clr = 1'b0;
        chk("stat_clr_drop", stat_drop_cnt, 0);
        chk("stat_clr_pkt", stat_pkt_cnt, 0);
`endif

        // Simultaneous 2-beat CC packets: p0 first, one idle cycle, then p1
        cc_log.delete(); cc_cyc.delete();
        cc_pk[0].push_back((2 << 8) | 8'h00);
        cc_pk[1].push_back((2 << 8) | 8'h10);
        step(15);
        chk("t3_count", cc_log.size(), 4);
        if (cc_log.size() == 4) begin
            chk("t3_b0", cc_log[0], cce(8'h00, 0, 1'b0));
            chk("t3_b1", cc_log[1], cce(8'h00, 1, 1'b1));
            chk("t3_b2", cc_log[2], cce(8'h10, 0, 1'b0));
            chk("t3_b3", cc_log[3], cce(8'h10, 1, 1'b1));
            chk("t3_back2back", cc_cyc[1] - cc_cyc[0], 1);
            chk("t3_bubble", cc_cyc[2] - cc_cyc[1], 2);
        end

        // Port0 backlog of 3, port1 one packet: p0,p1,p0,p0
        cc_log.delete(); cc_cyc.delete();
        cc_pk[0].push_back((1 << 8) | 8'h01);
        cc_pk[0].push_back((1 << 8) | 8'h02);
        cc_pk[0].push_back((1 << 8) | 8'h03);
        cc_pk[1].push_back((1 << 8) | 8'h11);
        step(20);
        chk("t4_count", cc_log.size(), 4);
        if (cc_log.size() == 4) begin
            chk("t4_o0", cc_log[0], cce(8'h01, 0, 1'b1));
            chk("t4_o1", cc_log[1], cce(8'h11, 0, 1'b1));
            chk("t4_o2", cc_log[2], cce(8'h02, 0, 1'b1));
            chk("t4_o3", cc_log[3], cce(8'h03, 0, 1'b1));
        end

        // Toggling core ready; p1's second packet must wait out p0's lock
        cc_log.delete(); cc_cyc.delete();
        rdy_toggle = 1'b1;
        cc_pk[1].push_back((1 << 8) | 8'h15);
        cc_pk[0].push_back((4 << 8) | 8'h05);
        cc_pk[1].push_back((1 << 8) | 8'h16);
        step(40);
        rdy_toggle = 1'b0;
        chk("t5_count", cc_log.size(), 6);
        if (cc_log.size() == 6) begin
            chk("t5_e0", cc_log[0], cce(8'h15, 0, 1'b1));
            chk("t5_e1", cc_log[1], cce(8'h05, 0, 1'b0));
            chk("t5_e2", cc_log[2], cce(8'h05, 1, 1'b0));
            chk("t5_e3", cc_log[3], cce(8'h05, 2, 1'b0));
            chk("t5_e4", cc_log[4], cce(8'h05, 3, 1'b1));
            chk("t5_e5", cc_log[5], cce(8'h16, 0, 1'b1));
        end

        // Reset in the middle of a CQ packet, then a fresh packet routes from SOP
        cq_out_tready = 2'b11;
        send_beat(0, 8'h30, 0, 1'b0, ok);
        send_beat(0, 8'h30, 1, 1'b0, ok);
        m_axis_cq_tvalid = 1'b0;
        reset_n = 1'b0;
        #2;
        chk("t6_rst_cq_tvalid", cq_out_tvalid, 2'b00);
        chk("t6_rst_cq_tready", m_axis_cq_tready, 1'b0);
        chk("t6_rst_cc_tvalid", s_axis_cc_tvalid, 1'b0);
        step(2);
        reset_n = 1'b1;
        step(2);
        cq_log.delete();
        send_cq(2, 1, 8'h60);
        step(4);
        chk("t6_count", cq_log.size(), 1);
        if (cq_log.size() == 1) chk("t6_beat", cq_log[0], cqe(1, 8'h60, 0, 1'b1));
`ifdef PCIE_ROUTER_STATS_EN
        chk("t6_stat_pkt1", stat_pkt_cnt[63:32], 1);
`endif

        chk("onehot", oh_viol, 0);
        chk("sideband", side_err, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
